// File: rtl/encrypt_pipe_pkg.sv
// ----------------------------------------------------------------------------
// encrypt_pipe_pkg
// Shared types and constants for the encrypter pipeline key-mixing stage.
//   km_state_t   : key-mix FSM states (KM_IDLE, KM_RUN)
//   byte_t       : one data/key byte
//   BYTE_CNT_MAX : saturation value of the per-run byte counter
//   rotl1()      : rotate a byte left by one bit (used by the optional
//                  rotate-on-wrap feature, ENCRYPT_KEY_ROTATE_EN)
// ----------------------------------------------------------------------------
package encrypt_pipe_pkg;

  typedef enum logic {
    KM_IDLE = 1'b0,
    KM_RUN  = 1'b1
  } km_state_t;

  typedef logic [7:0] byte_t;

  localparam logic [15:0] BYTE_CNT_MAX = 16'hFFFF;

  function automatic byte_t rotl1(input byte_t b);
    return {b[6:0], b[7]};
  endfunction

endpackage

// File: rtl/encrypt_key_bank.sv
// ----------------------------------------------------------------------------
// encrypt_key_bank
// KEY_DEPTH x 8-bit programmable key registers with one synchronous write
// port and one combinational read port.
//
// Optional feature (macro ENCRYPT_KEY_ROTATE_EN): when i_rot is high, keys
// 0..i_rot_len are each rotated left by one bit in place on the clock edge.
// The caller guarantees i_we and i_rot are never high together.
//
// Ports:
//   clk, rst    : clock, asynchronous active-low reset (all keys -> 0x00)
//   i_we        : write strobe
//   i_waddr     : write address
//   i_wdata     : write data
//   i_rot       : rotate strobe            (ENCRYPT_KEY_ROTATE_EN only)
//   i_rot_len   : last key index to rotate (ENCRYPT_KEY_ROTATE_EN only)
//   i_raddr     : read address
//   o_rdata     : key[i_raddr], combinational
// ----------------------------------------------------------------------------
module encrypt_key_bank
  import encrypt_pipe_pkg::*;
#(
  parameter  int KEY_DEPTH = 4,
  localparam int AW        = $clog2(KEY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  byte_t         i_wdata,
`ifdef ENCRYPT_KEY_ROTATE_EN
  input  logic          i_rot,
  input  logic [AW-1:0] i_rot_len,
`endif
  input  logic [AW-1:0] i_raddr,
  output byte_t         o_rdata
);

  byte_t r_key [KEY_DEPTH];

  // NOTE: the bank is a handful of flops, not a RAM macro, so every entry is
  // reset; a mid-run reset must leave no stale key material behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_DEPTH; i++) r_key[i] <= '0;
    end else begin
      if (i_we) r_key[i_waddr] <= i_wdata;
`ifdef ENCRYPT_KEY_ROTATE_EN
      if (i_rot) begin
        for (int i = 0; i < KEY_DEPTH; i++) begin
          if (AW'(i) <= i_rot_len) r_key[i] <= rotl1(r_key[i]);
        end
      end
`endif
    end
  end

  assign o_rdata = r_key[i_raddr];

endmodule

// File: rtl/encrypt_pipe_key_mix.sv
// ----------------------------------------------------------------------------
// encrypt_pipe_key_mix
// Key-mixing stage ahead of the permutation stage. Each accepted byte is
// XORed with key[key_idx]; key_idx advances per byte and wraps after the
// run's latched key length. Output pair is registered (1-cycle latency).
//
// Optional feature (macro ENCRYPT_KEY_ROTATE_EN): on each wrapping byte the
// active keys are rotated left by one bit after being used.
//
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   cfg_we     : key write strobe (honoured in IDLE, flagged in RUN)
//   cfg_addr   : key write address
//   cfg_wdata  : key write data
//   key_len    : last active key index, latched on start
//   start/stop : run control (start wins in IDLE, stop wins in RUN)
//   valid_in   : data_in valid
//   data_in    : plaintext byte
//   busy       : FSM is in RUN
//   cfg_err    : one-cycle pulse for a write attempted during RUN
//   key_idx    : key index for the next byte
//   byte_cnt   : bytes processed this run, saturating at 0xFFFF
//   valid_out  : data_out valid (to permutation en)
//   data_out   : mixed byte (to permutation data_in)
// ----------------------------------------------------------------------------
module encrypt_pipe_key_mix
  import encrypt_pipe_pkg::*;
#(
  parameter  int KEY_DEPTH = 4,
  localparam int AW        = $clog2(KEY_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [7:0]    cfg_wdata,
  input  logic [AW-1:0] key_len,
  input  logic          start,
  input  logic          stop,
  input  logic          valid_in,
  input  logic [7:0]    data_in,
  output logic          busy,
  output logic          cfg_err,
  output logic [AW-1:0] key_idx,
  output logic [15:0]   byte_cnt,
  output logic          valid_out,
  output logic [7:0]    data_out
);

  km_state_t     r_state;
  logic          r_busy;
  logic          r_cfg_err;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_key_idx;
  logic [15:0]   r_byte_cnt;
  logic          r_valid_out;
  byte_t         r_data_out;

  logic          w_in_run;
  logic          w_bank_we;
  logic          w_wrap;
  byte_t         w_key;

  assign w_in_run  = (r_state == KM_RUN);
  // Writes during RUN never reach the bank; they only raise cfg_err.
  assign w_bank_we = cfg_we && !w_in_run;
  assign w_wrap    = (r_key_idx == r_len);

  encrypt_key_bank #(
    .KEY_DEPTH (KEY_DEPTH)
  ) u_key_bank (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_bank_we),
    .i_waddr   (cfg_addr),
    .i_wdata   (cfg_wdata),
`ifdef ENCRYPT_KEY_ROTATE_EN
    // The wrapping byte reads the old key combinationally; rotation lands
    // on the same edge that registers that byte.
    .i_rot     (w_in_run && valid_in && w_wrap),
    .i_rot_len (r_len),
`endif
    .i_raddr   (r_key_idx),
    .o_rdata   (w_key)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge value of the registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= KM_IDLE;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_len       <= '0;
      r_key_idx   <= '0;
      r_byte_cnt  <= '0;
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
    end else begin
      r_cfg_err   <= 1'b0;
      r_valid_out <= 1'b0;
      case (r_state)
        KM_IDLE: begin
          if (start) begin
            r_state    <= KM_RUN;
            r_busy     <= 1'b1;
            r_len      <= key_len;
            r_key_idx  <= '0;
            r_byte_cnt <= '0;
          end
        end
        KM_RUN: begin
          r_cfg_err <= cfg_we;
          if (valid_in) begin
            r_data_out  <= data_in ^ w_key;
            r_valid_out <= 1'b1;
            r_key_idx   <= w_wrap ? '0 : r_key_idx + 1'b1;
            if (r_byte_cnt != BYTE_CNT_MAX) r_byte_cnt <= r_byte_cnt + 16'd1;
          end
          // The byte above is still processed on the stopping edge.
          if (stop) begin
            r_state <= KM_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= KM_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;
  assign key_idx   = r_key_idx;
  assign byte_cnt  = r_byte_cnt;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_encrypt_pipe_key_mix.sv
// ----------------------------------------------------------------------------
// tb_encrypt_pipe_key_mix
// Self-checking bench for encrypt_pipe_key_mix (KEY_DEPTH = 4). A behavioural
// model updated on each rising edge predicts every output; a compare process
// checks all outputs on each falling edge. Directed literal checks pin the
// model to hand-computed values. Honours ENCRYPT_KEY_ROTATE_EN if defined.
// ----------------------------------------------------------------------------
module tb_encrypt_pipe_key_mix;

  localparam int KD = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [7:0]    cfg_wdata = '0;
  logic [AW-1:0] key_len = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          valid_in = 1'b0;
  logic [7:0]    data_in = '0;
  logic          busy;
  logic          cfg_err;
  logic [AW-1:0] key_idx;
  logic [15:0]   byte_cnt;
  logic          valid_out;
  logic [7:0]    data_out;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  encrypt_pipe_key_mix #(.KEY_DEPTH(KD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .key_len   (key_len),
    .start     (start),
    .stop      (stop),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .busy      (busy),
    .cfg_err   (cfg_err),
    .key_idx   (key_idx),
    .byte_cnt  (byte_cnt),
    .valid_out (valid_out),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int   m_key [KD];
  bit   m_run;
  int   m_len, m_idx, m_cnt;
  bit   m_vo, m_err;
  int   m_do;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KD; i++) m_key[i] = 0;
      m_run = 0; m_len = 0; m_idx = 0; m_cnt = 0;
      m_vo = 0; m_err = 0; m_do = 0;
    end else if (!m_run) begin
      m_vo  = 0;
      m_err = 0;
      if (cfg_we) m_key[cfg_addr] = cfg_wdata;
      if (start) begin
        m_run = 1; m_len = key_len; m_idx = 0; m_cnt = 0;
      end
    end else begin
      m_err = cfg_we;
      m_vo  = valid_in;
      if (valid_in) begin
        m_do  = data_in ^ m_key[m_idx];
        m_cnt = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
`ifdef ENCRYPT_KEY_ROTATE_EN
        if (m_idx == m_len)
          for (int i = 0; i <= m_len; i++)
            m_key[i] = ((m_key[i] * 2) % 256) + (m_key[i] / 128);
`endif
        m_idx = (m_idx + 1) % (m_len + 1);
      end
      if (stop) m_run = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("busy",      busy,      m_run);
      check("cfg_err",   cfg_err,   m_err);
      check("key_idx",   key_idx,   m_idx);
      check("byte_cnt",  byte_cnt,  m_cnt);
      check("valid_out", valid_out, m_vo);
      check("data_out",  data_out,  m_do);
    end
  end

  // ---------------- stimulus helpers ----------------
  // Drive one cycle of inputs; returns 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic s, input logic p,
                     input logic we = 1'b0, input logic [AW-1:0] a = '0,
                     input logic [7:0] wd = '0, input logic [AW-1:0] kl = '0);
    @(negedge clk);
    valid_in = v; data_in = d; start = s; stop = p;
    cfg_we = we; cfg_addr = a; cfg_wdata = wd; key_len = kl;
    @(posedge clk);
    #1;
  endtask

  task automatic prog_std_keys();
    cyc(0, 0, 0, 0, 1, 2'd0, 8'hA5);
    cyc(0, 0, 0, 0, 1, 2'd1, 8'h3C);
    cyc(0, 0, 0, 0, 1, 2'd2, 8'h0F);
    cyc(0, 0, 0, 0, 1, 2'd3, 8'hF0);
  endtask

  logic [7:0] exp_b;

  initial begin
    // Reset state
    #1;
    check("rst_busy",   busy,      0);
    check("rst_vo",     valid_out, 0);
    check("rst_do",     data_out,  0);
    check("rst_cnt",    byte_cnt,  0);
    check("rst_idx",    key_idx,   0);
    check("rst_err",    cfg_err,   0);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Basic keystream
    prog_std_keys();
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd3);
    check("basic_busy", busy, 1);
    cyc(1, 8'h00, 0, 0); check("basic0", data_out, 8'hA5);
    cyc(1, 8'h00, 0, 0); check("basic1", data_out, 8'h3C);
    cyc(1, 8'h00, 0, 0); check("basic2", data_out, 8'h0F);
    cyc(1, 8'h00, 0, 0); check("basic3", data_out, 8'hF0);
    cyc(1, 8'h00, 0, 0);
`ifdef ENCRYPT_KEY_ROTATE_EN
    exp_b = 8'h4B;
`else
    exp_b = 8'hA5;
`endif
    check("basic4", data_out, exp_b);
    check("basic_cnt", byte_cnt, 5);
    cyc(0, 0, 0, 1);
    check("basic_stop", busy, 0);

    // Gaps and wrap
    prog_std_keys();
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd1);
    cyc(1, 8'hFF, 0, 0); check("gap0", data_out, 8'h5A);
    cyc(0, 8'h00, 0, 0); check("gap_vo", valid_out, 0); check("gap_idx", key_idx, 1);
    cyc(1, 8'hFF, 0, 0); check("gap1", data_out, 8'hC3);
    cyc(1, 8'hFF, 0, 0);
`ifdef ENCRYPT_KEY_ROTATE_EN
    exp_b = 8'hB4;
`else
    exp_b = 8'h5A;
`endif
    check("gap2", data_out, exp_b);
    cyc(0, 0, 0, 1);

    // Config during RUN
    prog_std_keys();
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd3);
    cyc(0, 0, 0, 0, 1, 2'd0, 8'h11); check("cfgerr_hi", cfg_err, 1);
    cyc(1, 8'h00, 0, 0); check("cfgerr_lo", cfg_err, 0); check("cfg_keep", data_out, 8'hA5);
    cyc(0, 0, 0, 1);

    // Simultaneous controls
    prog_std_keys();
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd3);
    cyc(1, 8'h01, 0, 1); check("stopbyte", data_out, 8'hA4); check("stop_busy", busy, 0);
    cyc(0, 0, 0, 0); check("idle_vo", valid_out, 0);
    cyc(0, 0, 1, 1, 0, 0, 0, 2'd3); check("startstop_idle", busy, 1);
    cyc(1, 8'h00, 0, 0);
    cyc(1, 8'h00, 1, 0); check("start_in_run", key_idx, 2);
    cyc(0, 0, 1, 1); check("startstop_run", busy, 0);
    cyc(0, 0, 1, 0, 1, 2'd0, 8'h77, 2'd3);
    cyc(1, 8'h00, 0, 0); check("we_start", data_out, 8'h77);
    cyc(0, 0, 0, 1);

    // Reset mid-run
    prog_std_keys();
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd3);
    cyc(1, 8'h12, 0, 0);
    cyc(1, 8'h34, 0, 0);
    #2 rst = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_vo",   valid_out, 0);
    check("mrst_do",   data_out, 0);
    check("mrst_cnt",  byte_cnt, 0);
    check("mrst_idx",  key_idx, 0);
    @(negedge clk);
    valid_in = 1'b0;
    #1 rst = 1'b1;
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd0);
    cyc(1, 8'h77, 0, 0); check("post_rst", data_out, 8'h77);
    cyc(1, 8'h12, 0, 0); check("len0_idx", key_idx, 0); check("len0_do", data_out, 8'h12);
    cyc(0, 0, 0, 1);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
          AW'($urandom), 8'($urandom), AW'($urandom));
    end
    cyc(0, 0, 0, 1);

    // Counter saturation
    for (int i = 0; i < KD; i++) cyc(0, 0, 0, 0, 1, AW'(i), 8'($urandom));
    cyc(0, 0, 1, 0, 0, 0, 0, 2'd2);
    for (int n = 0; n < 65537; n++) cyc(1, 8'($urandom), 0, 0);
    check("sat_cnt", byte_cnt, 16'hFFFF);
    cyc(1, 8'h5C, 0, 1);
    check("sat_hold", byte_cnt, 16'hFFFF);
    cyc(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/encrypt_pipe_key_mix.md
# encrypt_pipe_key_mix

Key-mixing stage placed directly upstream of the encrypter permutation stage. It XORs each incoming byte with one entry of a small programmable key bank. A key index advances on every accepted byte and wraps at a programmable key length. The registered `valid_out`/`data_out` pair drives the permutation stage's `en`/`data_in` with a one-cycle latency.

## Interface
- `KEY_DEPTH`, default 4: number of 8-bit key registers; power of two, ≥2. `AW = $clog2(KEY_DEPTH)`.
- Reset is `rst`, asynchronous, active-low. The clock is `clk`.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  key-bank write strobe
- `cfg_addr`  in  AW  key-bank write address
- `cfg_wdata`  in  8  key value to write
- `key_len`  in  AW  last active key index; sampled on `start`
- `start`  in  1  begin a run
- `stop`  in  1  end a run
- `valid_in`  in  1  `data_in` is valid this cycle
- `data_in`  in  8  plaintext byte
- `busy`  out  1  FSM is in RUN
- `cfg_err`  out  1  one-cycle pulse: write attempted during RUN
- `key_idx`  out  AW  key index that will be applied to the next byte
- `byte_cnt`  out  16  bytes processed in the current run, saturating
- `valid_out`  out  1  `data_out` is valid; connects to permutation `en`
- `data_out`  out  8  mixed byte; connects to permutation `data_in`

## Operation
- Two-state FSM, IDLE and RUN. Reset state is IDLE.
- **IDLE:**
  - `cfg_we` writes `cfg_wdata` into `key[cfg_addr]`.
  - `valid_in` is ignored.
  - `start` moves the FSM to RUN. On that edge it also latches `len_q <= key_len`, clears `key_idx` to 0 and clears `byte_cnt` to 0.
  - `stop` is ignored.
- **RUN, per accepted byte (`valid_in=1`):**
  - `data_out <= data_in ^ key[key_idx]` and `valid_out <= 1`.
  - `key_idx <= (key_idx == len_q) ? 0 : key_idx + 1`.
  - `byte_cnt` increments and holds at 0xFFFF once it gets there.
- **RUN, no byte (`valid_in=0`):** `valid_out <= 0`. `data_out`, `key_idx` and `byte_cnt` hold.
- **RUN, config write:** `cfg_we=1` does not modify the bank and `cfg_err <= 1` for one cycle. In every other case `cfg_err <= 0`.
- **`stop` in RUN:** the FSM returns to IDLE on the next edge. A byte presented with `valid_in` in the same cycle is still processed.
- **Simultaneous events:**
  - `start` and `stop` together in IDLE: `start` wins.
  - `start` and `stop` together in RUN: `stop` wins.
  - `start` asserted in RUN: ignored; the index is not restarted.
  - `cfg_we` and `start` together in IDLE: the write completes and the run starts. The new key is visible from the first byte of the run.
- **`key_len` = 0:** a single key is applied to every byte and `key_idx` stays at 0.
- **After returning to IDLE:** `byte_cnt` and `key_idx` hold their last values until the next `start`.

## Timing
- Latency is 1 cycle from `valid_in`/`data_in` to `valid_out`/`data_out`. Throughput is 1 byte per cycle with no backpressure.
- `busy` is registered. It rises the cycle after `start` and falls the cycle after `stop`.
- Reset values:
  - `busy` = 0, `cfg_err` = 0, `key_idx` = 0, `byte_cnt` = 0, `valid_out` = 0, `data_out` = 0x00.
  - Every key register = 0x00.
- Reset asserted mid-run: all outputs and the key bank return to their reset values immediately (asynchronous). Any in-flight byte is lost.
- `valid_out` is low in every cycle following an IDLE cycle.

## Configuration
- Macro `ENCRYPT_KEY_ROTATE_EN`.
- **Defined:**
  - In RUN, on every byte where `key_idx == len_q`, keys 0..`len_q` are each rotated left by 1 bit in place. The wrapping byte itself uses the pre-rotation key.
  - Rotation persists in the bank until the keys are rewritten.
  - If `cfg_we` coincides with a rotation it is already rejected by the RUN rule, so the two never conflict.
- **Undefined:** the key bank is static during a run. No rotation logic is generated.

## Structure
- Shared package `encrypt_pipe_pkg` holds:
  - the FSM enum `km_state_t` (`KM_IDLE`, `KM_RUN`);
  - `typedef logic [7:0] byte_t`;
  - the constant `BYTE_CNT_MAX = 16'hFFFF`.
- One sub-module, `encrypt_key_bank`:
  - holds the KEY_DEPTH×8 registers;
  - has a write port and a combinational read port;
  - contains the rotate-on-wrap logic under the macro.
- The FSM, index counter, byte counter and output register live in the top module.

## Test plan
- **Basic keystream.** Program keys {0xA5, 0x3C, 0x0F, 0xF0}, `key_len`=3, `start`, then 5 bytes of 0x00 back to back.
  - Macro undefined: `data_out` = A5, 3C, 0F, F0, A5, each one cycle after its input. `byte_cnt` ends at 5.
  - Macro defined: the fifth byte is 0x4B.
- **Gaps and wrap.** `key_len`=1, bytes 0xFF, idle cycle, 0xFF, 0xFF.
  - Outputs are 5A, C3, 5A.
  - `valid_out` is 0 in the gap cycle and `key_idx` holds during it.
- **Config during RUN.** In RUN, drive `cfg_we` with `addr` 0 and `data` 0x11.
  - `cfg_err` pulses once.
  - The next byte 0x00 still yields 0xA5.
- **Simultaneous controls.**
  - `stop` with `valid_in` (byte 0x01, `key_idx`=0): output 0xA4, then `busy` falls.
  - `start` and `stop` together in IDLE: `busy` rises.
- **Reset mid-run.** Assert `rst` low after 2 bytes.
  - All outputs and keys read 0.
  - After restart, byte 0x77 yields 0x77.
- **Counter saturation.** Force 65,537 bytes.
  - `byte_cnt` holds at 0xFFFF.
  - `data_out` keeps cycling through the keys.
